// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD serial arithmetic blocks.
//   DIGIT_W   : bits per BCD digit
//   BCD_MAX   : largest legal digit value
//   BCD_RADIX : decimal radix used for the ten-correction
//   state_e   : sequencing FSM encoding (IDLE, RUN, FIN)
//   digit_ok  : returns 1 when a 4-bit digit is a legal BCD value
package bcd_pkg;

  localparam int         DIGIT_W   = 4;
  localparam logic [3:0] BCD_MAX   = 4'd9;
  localparam logic [3:0] BCD_RADIX = 4'd10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  function automatic logic digit_ok(input logic [DIGIT_W-1:0] digit);
    digit_ok = (digit <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_sub.sv
// Single-digit BCD subtractor with ten-correction (combinational).
//   a, b : minuend / subtrahend digit
//   bin  : borrow in from the less significant digit
//   d    : result digit (0..9 for legal inputs)
//   bout : borrow out to the next digit
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               bin,
  output logic [DIGIT_W-1:0] d,
  output logic               bout
);

  logic [DIGIT_W:0] t_s;

  // 5-bit signed difference; bit 4 is the sign, so a negative result
  // gets ten added back (the +10 wraps correctly in the low four bits).
  always_comb begin
    t_s = {1'b0, a} - {1'b0, b} - {4'd0, bin};
    if (t_s[DIGIT_W]) begin
      d    = t_s[DIGIT_W-1:0] + BCD_RADIX;
      bout = 1'b1;
    end else begin
      d    = t_s[DIGIT_W-1:0];
      bout = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial BCD subtractor: Diff = A - B, least-significant digit first,
// one digit per clock, with a start/busy/done handshake.
//   clk, rst : clock, synchronous active-high reset
//   start    : request, accepted only in IDLE
//   A, B     : packed BCD operands, sampled at acceptance only
//   Diff     : packed BCD result (ten's complement when Borrow=1)
//   Borrow   : final borrow, 1 when A < B
//   Invalid  : some operand digit was > 9 (Diff and Borrow forced to 0)
//   busy     : high from the cycle after acceptance through the done cycle
//   done     : one-cycle pulse; results hold afterwards until the next start
module bcd_serial_subtractor
  import bcd_pkg::*;
#(
  parameter int NDIGITS = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [DIGIT_W*NDIGITS-1:0] A,
  input  logic [DIGIT_W*NDIGITS-1:0] B,
  output logic [DIGIT_W*NDIGITS-1:0] Diff,
  output logic                       Borrow,
  output logic                       Invalid,
  output logic                       busy,
  output logic                       done
);

  localparam int W     = DIGIT_W * NDIGITS;
  localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIGITS - 1);

  state_e             state_r, next_state_s;
  logic [W-1:0]       a_r, b_r, diff_r;
  logic [IDX_W-1:0]   idx_r;
  logic               borrow_r, borrow_out_r, invalid_r, busy_r, done_r;
  logic               any_bad_s, last_s;
  logic [DIGIT_W-1:0] d_s;
  logic               bout_s;

  assign last_s = (idx_r == LAST_IDX);

  // One shared digit slice, steered by the running digit index.
  bcd_digit_sub u_digit (
    .a    (a_r[idx_r*DIGIT_W +: DIGIT_W]),
    .b    (b_r[idx_r*DIGIT_W +: DIGIT_W]),
    .bin  (borrow_r),
    .d    (d_s),
    .bout (bout_s)
  );

  // Flag any non-BCD digit on the live operand inputs (used at acceptance).
  always_comb begin
    any_bad_s = 1'b0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (!digit_ok(A[i*DIGIT_W +: DIGIT_W]) || !digit_ok(B[i*DIGIT_W +: DIGIT_W])) begin
        any_bad_s = 1'b1;
      end else begin
        any_bad_s = any_bad_s;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; invalid operands skip RUN and finish immediately.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (any_bad_s) begin
            next_state_s = FIN;
          end else begin
            next_state_s = RUN;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          next_state_s = FIN;
        end else begin
          next_state_s = RUN;
        end
      end
      FIN:     next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Datapath: operand capture, per-digit result write, borrow tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r          <= '0;
      b_r          <= '0;
      diff_r       <= '0;
      idx_r        <= '0;
      borrow_r     <= 1'b0;
      borrow_out_r <= 1'b0;
      invalid_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            a_r          <= A;
            b_r          <= B;
            diff_r       <= '0;
            idx_r        <= '0;
            borrow_r     <= 1'b0;
            borrow_out_r <= 1'b0;
            invalid_r    <= any_bad_s;
          end
        end
        RUN: begin
          diff_r[idx_r*DIGIT_W +: DIGIT_W] <= d_s;
          borrow_r <= bout_s;
          idx_r    <= idx_r + IDX_W'(1);
          if (last_s) begin
            borrow_out_r <= bout_s;
          end
        end
        FIN: begin
          idx_r <= '0;
        end
        default: begin
          idx_r <= '0;
        end
      endcase
    end
  end

  // Registered handshake outputs, derived from the upcoming state.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (next_state_s != IDLE);
      done_r <= (next_state_s == FIN);
    end
  end

  assign Diff    = diff_r;
  assign Borrow  = borrow_out_r;
  assign Invalid = invalid_r;
  assign busy    = busy_r;
  assign done    = done_r;

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Self-checking bench for bcd_serial_subtractor (NDIGITS=4).
module tb_bcd_serial_subtractor;

  localparam int ND = 4;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [15:0] A, B;
  logic [15:0] Diff;
  logic        Borrow, Invalid, busy, done;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    logic [15:0] diff;
    logic        borrow;
    logic        invalid;
    int          lat;
  } exp_t;

  exp_t sb_q[$];

  bcd_serial_subtractor #(.NDIGITS(ND)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .Diff(Diff), .Borrow(Borrow), .Invalid(Invalid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int bcd2int(input logic [15:0] v);
    int r = 0;
    for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(input int x);
    logic [15:0] r;
    int y = x;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(y % 10);
      y = y / 10;
    end
    return r;
  endfunction

  function automatic bit bcd_ok(input logic [15:0] v);
    for (int i = 0; i < 4; i++) if (v[i*4 +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    int d;
    if (!bcd_ok(a) || !bcd_ok(b)) begin
      e.diff = 16'h0000; e.borrow = 1'b0; e.invalid = 1'b1; e.lat = 1;
    end else begin
      d = bcd2int(a) - bcd2int(b);
      e.borrow = (d < 0);
      if (d < 0) d = d + 10000;
      e.diff = int2bcd(d); e.invalid = 1'b0; e.lat = ND + 1;
    end
    return e;
  endfunction

  // Push expectation and pulse start for one cycle; returns in cycle 1.
  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    sb_q.push_back(model(a, b));
    A = a; B = b; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Wait (bounded) for done; lat is the cycle index relative to acceptance.
  task automatic wait_done(output int lat, output bit gap);
    lat = 1; gap = 1'b0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy !== 1'b1) gap = 1'b1;
      tick();
      lat++;
    end
    if (busy !== 1'b1) gap = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; A = 16'h0042; B = 16'h0017;
    tick(); tick();
    total_cnt++; if ({busy, done} !== 2'b00) $display("FAIL reset_hs: got %b expected 00", {busy, done}); else pass_cnt++;
    total_cnt++; if (Diff !== 16'h0000) $display("FAIL reset_diff: got %h expected 0000", Diff); else pass_cnt++;
    total_cnt++; if ({Borrow, Invalid} !== 2'b00) $display("FAIL reset_flags: got %b expected 00", {Borrow, Invalid}); else pass_cnt++;
    rst = 1'b0; start = 1'b0;
    tick();
    total_cnt++; if (busy !== 1'b0) $display("FAIL rst_beats_start: busy got %b expected 0", busy); else pass_cnt++;
  endtask

  task automatic test_arith();
    logic [15:0] at [8] = '{16'h0042, 16'h0017, 16'h1000, 16'h0005, 16'h9999, 16'h0000, 16'h5678, 16'h0000};
    logic [15:0] bt [8] = '{16'h0017, 16'h0042, 16'h0001, 16'h0005, 16'h0000, 16'h0001, 16'h1234, 16'h9999};
    exp_t e; int lat; bit gap;
    for (int i = 0; i < 12; i++) begin
      if (i < 8) issue(at[i], bt[i]);
      else issue(int2bcd($urandom_range(0, 9999)), int2bcd($urandom_range(0, 9999)));
      wait_done(lat, gap);
      e = sb_q.pop_front();
      total_cnt++; if (lat !== e.lat) $display("FAIL arith_lat[%0d]: got %0d expected %0d", i, lat, e.lat); else pass_cnt++;
      total_cnt++; if (gap !== 1'b0) $display("FAIL arith_busy[%0d]: busy dropped before done", i); else pass_cnt++;
      total_cnt++; if (Diff !== e.diff) $display("FAIL arith_diff[%0d]: got %h expected %h", i, Diff, e.diff); else pass_cnt++;
      total_cnt++; if (Borrow !== e.borrow) $display("FAIL arith_borrow[%0d]: got %b expected %b", i, Borrow, e.borrow); else pass_cnt++;
      total_cnt++; if (Invalid !== 1'b0) $display("FAIL arith_invalid[%0d]: got %b expected 0", i, Invalid); else pass_cnt++;
      tick();
      total_cnt++; if ({busy, done} !== 2'b00) $display("FAIL arith_done_pulse[%0d]: busy,done got %b expected 00", i, {busy, done}); else pass_cnt++;
    end
  endtask

  task automatic test_invalid();
    logic [15:0] at [3] = '{16'h00A1, 16'h0005, 16'h0001};
    logic [15:0] bt [3] = '{16'h0001, 16'h0005, 16'hF000};
    exp_t e; int lat; bit gap;
    for (int i = 0; i < 3; i++) begin
      issue(at[i], bt[i]);
      wait_done(lat, gap);
      e = sb_q.pop_front();
      total_cnt++; if (lat !== e.lat) $display("FAIL inv_lat[%0d]: got %0d expected %0d", i, lat, e.lat); else pass_cnt++;
      total_cnt++; if (Invalid !== e.invalid) $display("FAIL inv_flag[%0d]: got %b expected %b", i, Invalid, e.invalid); else pass_cnt++;
      total_cnt++; if ({Diff, Borrow} !== {e.diff, e.borrow}) $display("FAIL inv_result[%0d]: got %h/%b expected %h/%b", i, Diff, Borrow, e.diff, e.borrow); else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_ignore_start();
    exp_t e; int lat; bit gap;
    issue(16'h0042, 16'h0017);                    // now in cycle 1
    tick();                                       // cycle 2
    A = 16'h0099; B = 16'h0001; start = 1'b1;
    tick();                                       // cycle 3
    start = 1'b0;
    tick(); tick();                               // cycle 5
    total_cnt++; if (done !== 1'b1) $display("FAIL ign_done5: got %b expected 1", done); else pass_cnt++;
    e = sb_q.pop_front();
    total_cnt++; if ({Diff, Borrow} !== {e.diff, e.borrow}) $display("FAIL ign_result: got %h/%b expected %h/%b", Diff, Borrow, e.diff, e.borrow); else pass_cnt++;
    start = 1'b1;                                 // start during FIN: ignored
    tick();                                       // cycle 6, IDLE
    total_cnt++; if ({busy, done} !== 2'b00) $display("FAIL ign_fin_start: busy,done got %b expected 00", {busy, done}); else pass_cnt++;
    sb_q.push_back(model(A, B));                  // start still high: accepted now
    tick();
    start = 1'b0;
    wait_done(lat, gap);
    e = sb_q.pop_front();
    total_cnt++; if (lat !== e.lat) $display("FAIL ign_second_lat: got %0d expected %0d", lat, e.lat); else pass_cnt++;
    total_cnt++; if (Diff !== e.diff) $display("FAIL ign_second_diff: got %h expected %h", Diff, e.diff); else pass_cnt++;
    tick();
  endtask

  task automatic test_rst_mid();
    exp_t e; int seen = 0;
    issue(16'h0042, 16'h0017);
    tick(); tick();                               // cycle 3
    rst = 1'b1;
    tick();
    rst = 1'b0;
    e = sb_q.pop_front();                         // aborted operation
    total_cnt++; if ({busy, done} !== 2'b00) $display("FAIL rstmid_hs: got %b expected 00", {busy, done}); else pass_cnt++;
    total_cnt++; if ({Diff, Borrow, Invalid} !== 18'h0) $display("FAIL rstmid_out: got %h/%b/%b expected 0000/0/0", Diff, Borrow, Invalid); else pass_cnt++;
    for (int i = 0; i < 10; i++) begin
      if (done === 1'b1) seen++;
      tick();
    end
    total_cnt++; if (seen !== 0) $display("FAIL rstmid_no_done: got %0d done cycles expected 0 (aborted %h)", seen, e.diff); else pass_cnt++;
  endtask

  task automatic test_operand_change();
    exp_t e; int lat; bit gap;
    issue(16'h0042, 16'h0017);
    A = 16'h9999; B = 16'h0999;                   // cycle 1 change
    wait_done(lat, gap);
    e = sb_q.pop_front();
    total_cnt++; if (Diff !== e.diff) $display("FAIL opchg_diff: got %h expected %h", Diff, e.diff); else pass_cnt++;
    tick();
  endtask

  task automatic test_back_to_back();
    exp_t e; int lat; bit gap;
    issue(16'h1000, 16'h0001);
    wait_done(lat, gap);
    e = sb_q.pop_front();
    total_cnt++; if (Diff !== e.diff) $display("FAIL b2b_first: got %h expected %h", Diff, e.diff); else pass_cnt++;
    tick();                                       // first IDLE cycle after done
    issue(16'h0300, 16'h0450);
    wait_done(lat, gap);
    e = sb_q.pop_front();
    total_cnt++; if (lat !== e.lat) $display("FAIL b2b_lat: got %0d expected %0d", lat, e.lat); else pass_cnt++;
    total_cnt++; if ({Diff, Borrow} !== {e.diff, e.borrow}) $display("FAIL b2b_second: got %h/%b expected %h/%b", Diff, Borrow, e.diff, e.borrow); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      A = 16'h0000; B = 16'h1111;
      tick();
    end
    total_cnt++; if ({Diff, Borrow, Invalid} !== {e.diff, e.borrow, 1'b0}) $display("FAIL b2b_hold: got %h/%b/%b expected %h/%b/0", Diff, Borrow, Invalid, e.diff, e.borrow); else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; A = 16'h0; B = 16'h0;
    test_reset();
    test_arith();
    test_invalid();
    test_ignore_start();
    test_rst_mid();
    test_operand_change();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
